// File: rtl/fpu_op_sequencer.sv
// fpu_op_sequencer
//   Sequences one single-precision FP op (add.s / sub.s / mul.s) at a time
//   through a shared FP core: read the FPR operands, launch the core,
//   wait for done (bounded by TIMEOUT), then write the result back.
//   Back-pressures decode while busy and flags mfc1 read-after-write hazards.
//
// Ports
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_op_valid/o_op_ready   decode handshake; i_op_code/fd/fs/ft op fields
//   o_fpr_ra1/2, i_fpr_rd1/2  FPR read port (combinational-read file)
//   o_fpu_start/sel/a/b     FP core launch; i_fpu_done/i_fpu_result return
//   o_fpr_we/wa/wd          FPR write port
//   i_haz_addr/o_haz_stall  mfc1 hazard check against in-flight destination
//   o_illegal_op            one-cycle pulse for accepted op_code 11
//   o_timeout_err/i_err_clr sticky abort flag and its clear
module fpu_op_sequencer #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CW      = 5
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_op_valid,
    output logic        o_op_ready,
    input  logic [1:0]  i_op_code,
    input  logic [4:0]  i_op_fd,
    input  logic [4:0]  i_op_fs,
    input  logic [4:0]  i_op_ft,
    output logic [4:0]  o_fpr_ra1,
    output logic [4:0]  o_fpr_ra2,
    input  logic [31:0] i_fpr_rd1,
    input  logic [31:0] i_fpr_rd2,
    output logic        o_fpu_start,
    output logic [1:0]  o_fpu_sel,
    output logic [31:0] o_fpu_a,
    output logic [31:0] o_fpu_b,
    input  logic        i_fpu_done,
    input  logic [31:0] i_fpu_result,
    output logic        o_fpr_we,
    output logic [4:0]  o_fpr_wa,
    output logic [31:0] o_fpr_wd,
    input  logic [4:0]  i_haz_addr,
    output logic        o_haz_stall,
    output logic        o_illegal_op,
    output logic        o_timeout_err,
    input  logic        i_err_clr
);

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StLaunch,
        StWait,
        StWb
    } state_t;

    localparam logic [CW-1:0] CntLast = CW'(TIMEOUT - 1);

    state_t        r_state;
    logic [1:0]    r_op;
    logic [4:0]    r_fd;
    logic [4:0]    r_fs;
    logic [4:0]    r_ft;
    logic [31:0]   r_a;
    logic [31:0]   r_b;
    logic [31:0]   r_result;
    logic [CW-1:0] r_cnt;
    logic          r_start;
    logic          r_we;
    logic          r_illegal;
    logic          r_timeout_err;

    logic          w_idle;
    logic          w_read;

    assign w_idle = (r_state == StIdle);
    assign w_read = (r_state == StRead);

    // Gated by reset so ready is low while reset is held, high right after release.
    assign o_op_ready    = w_idle & i_rst_n;
    assign o_fpr_ra1     = w_read ? r_fs : 5'd0;
    assign o_fpr_ra2     = w_read ? r_ft : 5'd0;
    assign o_fpu_start   = r_start;
    assign o_fpu_sel     = r_op;
    assign o_fpu_a       = r_a;
    assign o_fpu_b       = r_b;
    assign o_fpr_we      = r_we;
    assign o_fpr_wa      = r_fd;
    assign o_fpr_wd      = r_result;
    assign o_haz_stall   = ~w_idle & (i_haz_addr == r_fd);
    assign o_illegal_op  = r_illegal;
    assign o_timeout_err = r_timeout_err;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= StIdle;
            r_op          <= 2'd0;
            r_fd          <= 5'd0;
            r_fs          <= 5'd0;
            r_ft          <= 5'd0;
            r_a           <= 32'd0;
            r_b           <= 32'd0;
            r_result      <= 32'd0;
            r_cnt         <= '0;
            r_start       <= 1'b0;
            r_we          <= 1'b0;
            r_illegal     <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_start   <= 1'b0;
            r_we      <= 1'b0;
            r_illegal <= 1'b0;
            // A timeout set later in this block overrides the clear.
            if (i_err_clr) begin
                r_timeout_err <= 1'b0;
            end
            unique case (r_state)
                StIdle: begin
                    if (i_op_valid) begin
                        if (i_op_code == 2'b11) begin
                            r_illegal <= 1'b1;
                        end else begin
                            r_op    <= i_op_code;
                            r_fd    <= i_op_fd;
                            r_fs    <= i_op_fs;
                            r_ft    <= i_op_ft;
                            r_state <= StRead;
                        end
                    end
                end
                StRead: begin
                    r_a     <= i_fpr_rd1;
                    r_b     <= i_fpr_rd2;
                    r_start <= 1'b1;
                    r_state <= StLaunch;
                end
                StLaunch: begin
                    r_cnt   <= '0;
                    r_state <= StWait;
                end
                StWait: begin
                    if (i_fpu_done) begin
                        r_result <= i_fpu_result;
                        r_we     <= 1'b1;
                        r_state  <= StWb;
                    end else if (r_cnt == CntLast) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= StIdle;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StWb: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

endmodule
